// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 mouse host sequencer: controller state
// encoding, PS/2 mouse command and response byte values, and a small helper
// that identifies the states belonging to an in-flight user command.
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [3:0] {
      ST_SEND_RST,  // issue 0xFF reset
      ST_TX_RST,    // wait for transceiver to finish sending 0xFF
      ST_ACK_RST,   // wait for 0xFA
      ST_BAT,       // wait for 0xAA self-test result
      ST_ID,        // wait for 0x00 device id
      ST_SEND_EN,   // issue 0xF4 enable reporting
      ST_TX_EN,     // wait for transceiver to finish sending 0xF4
      ST_ACK_EN,    // wait for 0xFA
      ST_STREAM,    // forwarding mouse data, accepting user commands
      ST_SEND_CMD,  // issue captured user command
      ST_TX_CMD,    // wait for transceiver to finish sending user command
      ST_ACK_CMD,   // wait for 0xFA, forwarding any other traffic
      ST_FAIL       // init exhausted its retries; waits for start
   } state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
   localparam logic [7:0] MOUSE_ID     = 8'h00;

   // True while a user command owns the transmitter.
   function automatic logic is_cmd_state(input state_t s);
      return (s == ST_SEND_CMD) || (s == ST_TX_CMD) || (s == ST_ACK_CMD);
   endfunction

endpackage

// File: rtl/ps2_timeout_cnt.sv
// -----------------------------------------------------------------------------
// ps2_timeout_cnt
// Free-running saturating cycle counter used as the response watchdog.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear to zero (highest priority after reset)
//   load       : synchronous load of load_val
//   load_val   : value loaded when load is high
//   limit      : compare value
//   hit        : high while the count equals limit
// The count sticks at all-ones so a long wait never wraps back through limit.
// -----------------------------------------------------------------------------
module ps2_timeout_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] limit,
   output logic         hit
);

   logic [W-1:0] cnt;

   // NOTE: sequential state is written with <= so every register samples the
   // pre-edge values of its inputs, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '1)
         cnt <= cnt + 1'b1;
   end

   assign hit = (cnt == limit);

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_mouse_ctrl
// Host-side sequencer sitting on top of a PS/2 rx/tx transceiver pair.
// After reset it initialises the mouse (0xFF reset -> FA/AA/00, then 0xF4
// enable -> FA), then streams received bytes out and lets one user command
// port borrow the transmitter, handling ACK, resend and timeouts.
//   clk, reset    : clock, asynchronous active-high reset
//   start         : pulse, restart initialisation from any state
//   wr_ps2        : one-cycle write strobe to the transceiver
//   tx_data       : byte for the transceiver, held until the next write
//   tx_done_tick  : transceiver finished sending
//   rx_done_tick  : transceiver received rx_data
//   cmd_req       : user command request (level, sampled in stream mode)
//   cmd_byte      : user command byte, captured on acceptance
//   cmd_busy      : user command in flight
//   cmd_done      : pulse, user command acknowledged
//   cmd_err       : pulse, user command gave up after MAX_RETRY retries
//   data_tick     : pulse, data_out holds a forwarded mouse byte
//   data_out      : forwarded mouse byte
//   ready         : initialisation complete (stream mode)
//   init_err      : initialisation failed
// -----------------------------------------------------------------------------
module ps2_mouse_ctrl
   import ps2_pkg::*;
#(
   parameter int ACK_TIMEOUT = 1_000_000,
   parameter int BAT_TIMEOUT = 50_000_000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       wr_ps2,
   output logic [7:0] tx_data,
   input  logic       tx_done_tick,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   input  logic       cmd_req,
   input  logic [7:0] cmd_byte,
   output logic       cmd_busy,
   output logic       cmd_done,
   output logic       cmd_err,
   output logic       data_tick,
   output logic [7:0] data_out,
   output logic       ready,
   output logic       init_err
);

   localparam int TW = $clog2(BAT_TIMEOUT + 1);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT);
   localparam logic [TW-1:0] BAT_LIM   = TW'(BAT_TIMEOUT);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

   state_t        state, state_nxt;
   logic [RW-1:0] init_retry, init_retry_nxt;
   logic [RW-1:0] cmd_retry, cmd_retry_nxt;
   logic [7:0]    cmd_reg, cmd_reg_nxt;
   logic [7:0]    tx_data_nxt, data_out_nxt;
   logic          wr_nxt, done_nxt, err_nxt, tick_nxt;
   logic          init_retry_req, cmd_retry_req, fwd;
   logic [TW-1:0] timer_limit;
   logic          timer_clr, timeout;

   // Watchdog restarts on every state change; only BAT gets the long limit.
   assign timer_limit = (state == ST_BAT) ? BAT_LIM : ACK_LIM;
   assign timer_clr   = (state_nxt != state);

   ps2_timeout_cnt #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr      (timer_clr),
      .load     (1'b0),
      .load_val ({TW{1'b0}}),
      .limit    (timer_limit),
      .hit      (timeout)
   );

   // Level outputs decode straight from the state register; SEND_RST is the
   // reset state, so all three are low during reset.
   assign ready    = (state == ST_STREAM) || is_cmd_state(state);
   assign cmd_busy = is_cmd_state(state);
   assign init_err = (state == ST_FAIL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_SEND_RST;
      else
         state <= state_nxt;
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt      = state;
      init_retry_nxt = init_retry;
      cmd_retry_nxt  = cmd_retry;
      cmd_reg_nxt    = cmd_reg;
      tx_data_nxt    = tx_data;
      data_out_nxt   = data_out;
      wr_nxt         = 1'b0;
      done_nxt       = 1'b0;
      err_nxt        = 1'b0;
      tick_nxt       = 1'b0;
      init_retry_req = 1'b0;
      cmd_retry_req  = 1'b0;
      fwd            = 1'b0;

      if (start) begin
         // Abandons anything in flight, including a user command, silently.
         state_nxt      = ST_SEND_RST;
         init_retry_nxt = '0;
         cmd_retry_nxt  = '0;
      end else begin
         // In every wait state a received byte is evaluated before the
         // timeout, so a byte arriving on the expiry cycle still counts.
         unique case (state)
            ST_SEND_RST: begin
               wr_nxt      = 1'b1;
               tx_data_nxt = CMD_RESET;
               state_nxt   = ST_TX_RST;
            end
            ST_TX_RST: begin
               if (tx_done_tick) state_nxt = ST_ACK_RST;
               else if (timeout) init_retry_req = 1'b1;
            end
            ST_ACK_RST: begin
               if (rx_done_tick) begin
                  if (rx_data == RSP_ACK)         state_nxt = ST_BAT;
                  else if (rx_data == RSP_RESEND) init_retry_req = 1'b1;
               end else if (timeout) begin
                  init_retry_req = 1'b1;
               end
            end
            ST_BAT: begin
               if (rx_done_tick) begin
                  if (rx_data == RSP_BAT_OK)        state_nxt = ST_ID;
                  else if (rx_data == RSP_BAT_FAIL) init_retry_req = 1'b1;
               end else if (timeout) begin
                  init_retry_req = 1'b1;
               end
            end
            ST_ID: begin
               if (rx_done_tick) begin
                  if (rx_data == MOUSE_ID) state_nxt = ST_SEND_EN;
                  else                     init_retry_req = 1'b1;
               end else if (timeout) begin
                  init_retry_req = 1'b1;
               end
            end
            ST_SEND_EN: begin
               wr_nxt      = 1'b1;
               tx_data_nxt = CMD_ENABLE;
               state_nxt   = ST_TX_EN;
            end
            ST_TX_EN: begin
               if (tx_done_tick) state_nxt = ST_ACK_EN;
               else if (timeout) init_retry_req = 1'b1;
            end
            ST_ACK_EN: begin
               if (rx_done_tick) begin
                  if (rx_data == RSP_ACK)         state_nxt = ST_STREAM;
                  else if (rx_data == RSP_RESEND) init_retry_req = 1'b1;
               end else if (timeout) begin
                  init_retry_req = 1'b1;
               end
            end
            ST_STREAM: begin
               fwd = rx_done_tick;
               if (cmd_req) begin
                  cmd_reg_nxt    = cmd_byte;
                  init_retry_nxt = '0;
                  cmd_retry_nxt  = '0;
                  state_nxt      = ST_SEND_CMD;
               end
            end
            ST_SEND_CMD: begin
               wr_nxt      = 1'b1;
               tx_data_nxt = cmd_reg;
               state_nxt   = ST_TX_CMD;
            end
            ST_TX_CMD: begin
               if (tx_done_tick) state_nxt = ST_ACK_CMD;
               else if (timeout) cmd_retry_req = 1'b1;
            end
            ST_ACK_CMD: begin
               if (rx_done_tick) begin
                  if (rx_data == RSP_ACK) begin
                     done_nxt  = 1'b1;
                     state_nxt = ST_STREAM;
                  end else if (rx_data == RSP_RESEND) begin
                     cmd_retry_req = 1'b1;
                  end else begin
                     // Movement packets can interleave with the ACK.
                     fwd = 1'b1;
                  end
               end else if (timeout) begin
                  cmd_retry_req = 1'b1;
               end
            end
            ST_FAIL: ;
            default: state_nxt = ST_SEND_RST;
         endcase

         // One retry budget covers the entire init sequence.
         if (init_retry_req) begin
            if (init_retry == RETRY_LIM) begin
               state_nxt = ST_FAIL;
            end else begin
               init_retry_nxt = init_retry + 1'b1;
               state_nxt      = ST_SEND_RST;
            end
         end

         if (cmd_retry_req) begin
            if (cmd_retry == RETRY_LIM) begin
               err_nxt   = 1'b1;
               state_nxt = ST_STREAM;
            end else begin
               cmd_retry_nxt = cmd_retry + 1'b1;
               state_nxt     = ST_SEND_CMD;
            end
         end

         if (fwd) begin
            tick_nxt     = 1'b1;
            data_out_nxt = rx_data;
         end

         if ((state_nxt == ST_STREAM) && (state != ST_STREAM)) begin
            init_retry_nxt = '0;
            cmd_retry_nxt  = '0;
         end
      end
   end

   // NOTE: every register here, including the captured command byte, is
   // reset so outputs are clean zeros from the moment reset asserts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_retry <= '0;
         cmd_retry  <= '0;
         cmd_reg    <= '0;
         tx_data    <= '0;
         data_out   <= '0;
         wr_ps2     <= 1'b0;
         cmd_done   <= 1'b0;
         cmd_err    <= 1'b0;
         data_tick  <= 1'b0;
      end else begin
         init_retry <= init_retry_nxt;
         cmd_retry  <= cmd_retry_nxt;
         cmd_reg    <= cmd_reg_nxt;
         tx_data    <= tx_data_nxt;
         data_out   <= data_out_nxt;
         wr_ps2     <= wr_nxt;
         cmd_done   <= done_nxt;
         cmd_err    <= err_nxt;
         data_tick  <= tick_nxt;
      end
   end

endmodule
